// File: rtl/rs_cdb_listener_pkg.sv
// rtl/rs_cdb_listener_pkg.sv - shared widths, no-producer label and entry state encoding
package rs_cdb_listener_pkg;

    localparam int LABEL_W = 4;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 2;

    // Label 0 is never owned by an entry: a Q of 0 means the operand value is present.
    localparam logic [LABEL_W-1:0] LABEL_NONE = '0;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } rs_state_t;

endpackage

// File: rtl/rs_cdb_listener_entry.sv
// rtl/rs_cdb_listener_entry.sv - one reservation-station entry (rs_entry): state machine, CDB snoop, own-label free
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_load                         take an issue this edge (only honoured while FREE)
//   i_op, i_qj, i_qk, i_vj, i_vk   issue payload, already bypass-resolved by the top
//   i_cdb_en/label/data            common-data-bus broadcast
//   i_dispatch                     functional unit accepted this entry (only honoured while READY)
//   o_state, o_op, o_vj, o_vk      registered entry contents
module rs_entry
    import rs_cdb_listener_pkg::*;
#(
    parameter logic [LABEL_W-1:0] MY_LABEL = 4'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [OP_W-1:0]     i_op,
    input  logic [LABEL_W-1:0]  i_qj,
    input  logic [LABEL_W-1:0]  i_qk,
    input  logic [DATA_W-1:0]   i_vj,
    input  logic [DATA_W-1:0]   i_vk,
    input  logic                i_cdb_en,
    input  logic [LABEL_W-1:0]  i_cdb_label,
    input  logic [DATA_W-1:0]   i_cdb_data,
    input  logic                i_dispatch,
    output rs_state_t           o_state,
    output logic [OP_W-1:0]     o_op,
    output logic [DATA_W-1:0]   o_vj,
    output logic [DATA_W-1:0]   o_vk
);

    rs_state_t              r_state, w_state;
    logic [OP_W-1:0]        r_op,    w_op;
    logic [LABEL_W-1:0]     r_qj,    w_qj;
    logic [LABEL_W-1:0]     r_qk,    w_qk;
    logic [DATA_W-1:0]      r_vj,    w_vj;
    logic [DATA_W-1:0]      r_vk,    w_vk;

    // A broadcast on label 0 must never match, otherwise it would overwrite present operands.
    logic w_cdb_hit;
    assign w_cdb_hit = i_cdb_en && (i_cdb_label != LABEL_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FREE;
            r_op    <= '0;
            r_qj    <= '0;
            r_qk    <= '0;
            r_vj    <= '0;
            r_vk    <= '0;
        end else begin
            r_state <= w_state;
            r_op    <= w_op;
            r_qj    <= w_qj;
            r_qk    <= w_qk;
            r_vj    <= w_vj;
            r_vk    <= w_vk;
        end
    end

    always_comb begin
        w_state = r_state;
        w_op    = r_op;
        w_qj    = r_qj;
        w_qk    = r_qk;
        w_vj    = r_vj;
        w_vk    = r_vk;
        case (r_state)
            ST_FREE: begin
                if (i_load) begin
                    w_op    = i_op;
                    w_qj    = i_qj;
                    w_qk    = i_qk;
                    w_vj    = i_vj;
                    w_vk    = i_vk;
                    w_state = ((i_qj == LABEL_NONE) && (i_qk == LABEL_NONE)) ? ST_READY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_cdb_hit && (r_qj == i_cdb_label)) begin
                    w_qj = LABEL_NONE;
                    w_vj = i_cdb_data;
                end
                if (w_cdb_hit && (r_qk == i_cdb_label)) begin
                    w_qk = LABEL_NONE;
                    w_vk = i_cdb_data;
                end
                if ((w_qj == LABEL_NONE) && (w_qk == LABEL_NONE)) begin
                    w_state = ST_READY;
                end
            end
            ST_READY: begin
                if (i_dispatch) begin
                    w_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Hold the label until its own result is broadcast so it is never reused early.
                if (w_cdb_hit && (i_cdb_label == MY_LABEL)) begin
                    w_state = ST_FREE;
                end
            end
            default: w_state = ST_FREE;
        endcase
    end

    assign o_state = r_state;
    assign o_op    = r_op;
    assign o_vj    = r_vj;
    assign o_vk    = r_vk;

endmodule

// File: rtl/rs_cdb_listener.sv
// rtl/rs_cdb_listener.sv - reservation station listening on the common data bus
//
// Optional feature macro: RS_CDB_BYPASS_EN (same-cycle CDB capture at issue).
// Without it, issue is blocked in any cycle carrying a broadcast.
//
// Ports:
//   clk, rst_n                              clock, asynchronous active-low reset
//   issueValid, issueOp, issueQj/Qk, issueVj/Vk   issue request from decode
//   issueReady, issueLabel                  issue accepted / label the issue would take
//   cdbEN, cdbLabel, cdbData                CDB broadcast
//   exValid, exOp, exA, exB, exLabel        dispatch to the functional unit
//   exReady                                 functional unit accepts the dispatch
module rs_cdb_listener
    import rs_cdb_listener_pkg::*;
#(
    parameter int                 DEPTH      = 3,
    parameter logic [LABEL_W-1:0] LABEL_BASE = 4'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issueValid,
    input  logic [OP_W-1:0]     issueOp,
    input  logic [LABEL_W-1:0]  issueQj,
    input  logic [LABEL_W-1:0]  issueQk,
    input  logic [DATA_W-1:0]   issueVj,
    input  logic [DATA_W-1:0]   issueVk,
    output logic                issueReady,
    output logic [LABEL_W-1:0]  issueLabel,
    input  logic                cdbEN,
    input  logic [LABEL_W-1:0]  cdbLabel,
    input  logic [DATA_W-1:0]   cdbData,
    output logic                exValid,
    output logic [OP_W-1:0]     exOp,
    output logic [DATA_W-1:0]   exA,
    output logic [DATA_W-1:0]   exB,
    output logic [LABEL_W-1:0]  exLabel,
    input  logic                exReady
);

    localparam int IDX_W = 2;

    rs_state_t              w_state [DEPTH];
    logic [OP_W-1:0]        w_op    [DEPTH];
    logic [DATA_W-1:0]      w_vj    [DEPTH];
    logic [DATA_W-1:0]      w_vk    [DEPTH];
    logic [DEPTH-1:0]       w_load;
    logic [DEPTH-1:0]       w_dispatch;

    logic                   w_any_free;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_any_ready;
    logic [IDX_W-1:0]       w_ready_idx;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_accept;

    logic [LABEL_W-1:0]     w_eff_qj, w_eff_qk;
    logic [DATA_W-1:0]      w_eff_vj, w_eff_vk;

    // Selection lock: once a dispatch is stalled, keep presenting the same entry even if a
    // lower-index entry becomes READY meanwhile, so ex* stay steady. The locked entry stays
    // READY because only an accepted dispatch moves it out of READY.
    logic                   r_lock;
    logic [IDX_W-1:0]       r_lock_idx;

    always_comb begin
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        w_any_ready = 1'b0;
        w_ready_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_state[i] == ST_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (w_state[i] == ST_READY) begin
                w_any_ready = 1'b1;
                w_ready_idx = IDX_W'(i);
            end
        end
    end

    assign w_sel_idx  = r_lock ? r_lock_idx : w_ready_idx;
    assign issueLabel = LABEL_BASE + LABEL_W'(w_free_idx);

`ifdef RS_CDB_BYPASS_EN
    logic w_byp_j, w_byp_k;
    assign w_byp_j    = cdbEN && (cdbLabel != LABEL_NONE) && (issueQj == cdbLabel);
    assign w_byp_k    = cdbEN && (cdbLabel != LABEL_NONE) && (issueQk == cdbLabel);
    assign w_eff_qj   = w_byp_j ? LABEL_NONE : issueQj;
    assign w_eff_qk   = w_byp_k ? LABEL_NONE : issueQk;
    assign w_eff_vj   = w_byp_j ? cdbData : issueVj;
    assign w_eff_vk   = w_byp_k ? cdbData : issueVk;
    assign issueReady = w_any_free;
`else
    // A new entry cannot see a broadcast made in its own issue cycle, so refuse issue then.
    assign w_eff_qj   = issueQj;
    assign w_eff_qk   = issueQk;
    assign w_eff_vj   = issueVj;
    assign w_eff_vk   = issueVk;
    assign issueReady = w_any_free && !cdbEN;
`endif

    assign w_accept = issueValid && issueReady;
    assign exValid  = w_any_ready;

    always_comb begin
        w_load     = '0;
        w_dispatch = '0;
        exOp       = '0;
        exA        = '0;
        exB        = '0;
        exLabel    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_accept && (w_free_idx == IDX_W'(i))) begin
                w_load[i] = 1'b1;
            end
            if (w_any_ready && (w_sel_idx == IDX_W'(i))) begin
                w_dispatch[i] = exReady;
                exOp          = w_op[i];
                exA           = w_vj[i];
                exB           = w_vk[i];
                exLabel       = LABEL_BASE + LABEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            r_lock     <= w_any_ready && !exReady;
            r_lock_idx <= w_sel_idx;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rs_entry #(
            .MY_LABEL (LABEL_BASE + LABEL_W'(g))
        ) u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_load      (w_load[g]),
            .i_op        (issueOp),
            .i_qj        (w_eff_qj),
            .i_qk        (w_eff_qk),
            .i_vj        (w_eff_vj),
            .i_vk        (w_eff_vk),
            .i_cdb_en    (cdbEN),
            .i_cdb_label (cdbLabel),
            .i_cdb_data  (cdbData),
            .i_dispatch  (w_dispatch[g]),
            .o_state     (w_state[g]),
            .o_op        (w_op[g]),
            .o_vj        (w_vj[g]),
            .o_vk        (w_vk[g])
        );
    end

endmodule

// File: tb/tb_rs_cdb_listener.sv
// tb/tb_rs_cdb_listener.sv - directed self-checking bench for rs_cdb_listener
module tb_rs_cdb_listener;

    logic        clk;
    logic        rst_n;
    logic        issueValid;
    logic [1:0]  issueOp;
    logic [3:0]  issueQj, issueQk;
    logic [31:0] issueVj, issueVk;
    logic        issueReady;
    logic [3:0]  issueLabel;
    logic        cdbEN;
    logic [3:0]  cdbLabel;
    logic [31:0] cdbData;
    logic        exValid;
    logic [1:0]  exOp;
    logic [31:0] exA, exB;
    logic [3:0]  exLabel;
    logic        exReady;

    int n_tests = 0;
    int n_fail  = 0;

    rs_cdb_listener #(
        .DEPTH      (3),
        .LABEL_BASE (4'd1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issueValid (issueValid),
        .issueOp    (issueOp),
        .issueQj    (issueQj),
        .issueQk    (issueQk),
        .issueVj    (issueVj),
        .issueVk    (issueVk),
        .issueReady (issueReady),
        .issueLabel (issueLabel),
        .cdbEN      (cdbEN),
        .cdbLabel   (cdbLabel),
        .cdbData    (cdbData),
        .exValid    (exValid),
        .exOp       (exOp),
        .exA        (exA),
        .exB        (exB),
        .exLabel    (exLabel),
        .exReady    (exReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] qj, input logic [31:0] vj,
                         input logic [3:0] qk, input logic [31:0] vk, input logic [3:0] exp_lbl);
        issueValid = 1'b1;
        issueOp    = op;
        issueQj    = qj;
        issueVj    = vj;
        issueQk    = qk;
        issueVk    = vk;
        #1;
        check("issue_label", issueLabel, exp_lbl);
        check("issue_ready", issueReady, 1);
        step();
        issueValid = 1'b0;
        #1;
    endtask

    task automatic bcast(input logic [3:0] lbl, input logic [31:0] data);
        cdbEN    = 1'b1;
        cdbLabel = lbl;
        cdbData  = data;
        step();
        cdbEN    = 1'b0;
        cdbLabel = '0;
        cdbData  = '0;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        issueValid = 1'b0;
        issueOp    = '0;
        issueQj    = '0;
        issueQk    = '0;
        issueVj    = '0;
        issueVk    = '0;
        cdbEN      = 1'b0;
        cdbLabel   = '0;
        cdbData    = '0;
        exReady    = 1'b0;
        #3;
        check("rst_issueReady", issueReady, 1);
        check("rst_issueLabel", issueLabel, 1);
        check("rst_exValid", exValid, 0);
        check("rst_exOp", exOp, 0);
        check("rst_exA", exA, 0);
        check("rst_exB", exB, 0);
        check("rst_exLabel", exLabel, 0);
        #10;
        rst_n = 1'b1;
        step();

        // Ready-at-issue entry dispatches next cycle and frees on its own broadcast.
        exReady = 1'b1;
        issue(2'd1, 4'd0, 32'd5, 4'd0, 32'd7, 4'd1);
        check("t1_exValid", exValid, 1);
        check("t1_exA", exA, 5);
        check("t1_exB", exB, 7);
        check("t1_exLabel", exLabel, 1);
        check("t1_exOp", exOp, 1);
        check("t1_nextLabel", issueLabel, 2);
        step();
        check("t1_exec_exValid", exValid, 0);
        check("t1_exec_exA", exA, 0);
        check("t1_exec_label", issueLabel, 2);
        bcast(4'd1, 32'h55);
        check("t1_freed_label", issueLabel, 1);

        // Two pending operands captured by separate broadcasts.
        issue(2'd0, 4'd2, 32'd0, 4'd3, 32'd0, 4'd1);
        check("t2_wait", exValid, 0);
        bcast(4'd2, 32'hAA);
        check("t2_half", exValid, 0);
        bcast(4'd3, 32'hBB);
        check("t2_exValid", exValid, 1);
        check("t2_exA", exA, 32'hAA);
        check("t2_exB", exB, 32'hBB);
        check("t2_exLabel", exLabel, 1);
        step();
        check("t2_exec", exValid, 0);
        bcast(4'd1, 32'h0);

        // Broadcasts on label 0 or with cdbEN low change nothing.
        issue(2'd3, 4'd5, 32'd0, 4'd0, 32'd4, 4'd1);
        cdbEN = 1'b1; cdbLabel = 4'd0; cdbData = 32'hDEAD;
        step();
        cdbEN = 1'b0; cdbLabel = 4'd5; cdbData = 32'h77;
        step();
        cdbLabel = 4'd0; cdbData = 32'h0;
        #1;
        check("t3_still_wait", exValid, 0);
        bcast(4'd5, 32'h66);
        check("t3_exValid", exValid, 1);
        check("t3_exA", exA, 32'h66);
        check("t3_exB", exB, 4);
        check("t3_exOp", exOp, 3);
        step();
        bcast(4'd1, 32'h0);

        // Fill all entries, ignore the extra issue, then drain in label order.
        exReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(2'd2, 4'd9, 32'd0, 4'd0, 32'(i + 1), 4'(i + 1));
        end
        check("t4_full", issueReady, 0);
        issueValid = 1'b1; issueQj = 4'd0; issueVj = 32'hEE; issueQk = 4'd0;
        step();
        issueValid = 1'b0;
        #1;
        check("t4_ignored_ready", issueReady, 0);
        check("t4_ignored_exValid", exValid, 0);
        bcast(4'd9, 32'h10);
        exReady = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t4_exValid", exValid, 1);
            check("t4_exLabel", exLabel, 32'(i + 1));
            check("t4_exA", exA, 32'h10);
            check("t4_exB", exB, 32'(i + 1));
            step();
        end
        check("t4_drained", exValid, 0);
        for (int l = 1; l <= 3; l++) begin
            bcast(4'(l), 32'h0);
        end
        check("t4_free_ready", issueReady, 1);
        check("t4_free_label", issueLabel, 1);

        // Same-cycle broadcast at issue.
        exReady    = 1'b0;
        issueValid = 1'b1; issueOp = 2'd1; issueQj = 4'd9; issueVj = 32'd0; issueQk = 4'd0; issueVk = 32'd2;
        cdbEN      = 1'b1; cdbLabel = 4'd9; cdbData = 32'h33;
        #1;
`ifdef RS_CDB_BYPASS_EN
        check("t5_byp_ready", issueReady, 1);
        step();
        issueValid = 1'b0; cdbEN = 1'b0; cdbLabel = '0; cdbData = '0;
        #1;
        check("t5_byp_exValid", exValid, 1);
        check("t5_byp_exA", exA, 32'h33);
        exReady = 1'b1;
        step();
        exReady = 1'b0;
        bcast(4'd1, 32'h0);
`else
        check("t5_blocked", issueReady, 0);
        step();
        issueValid = 1'b0; cdbEN = 1'b0; cdbLabel = '0; cdbData = '0;
        #1;
        check("t5_no_entry", exValid, 0);
        check("t5_label", issueLabel, 1);
        check("t5_ready", issueReady, 1);
`endif

        // Stalled dispatch holds steady; reset mid-EXEC discards everything.
        issue(2'd2, 4'd0, 32'h11, 4'd0, 32'h22, 4'd1);
        for (int i = 0; i < 5; i++) begin
            check("t6_hold_valid", exValid, 1);
            check("t6_hold_exA", exA, 32'h11);
            check("t6_hold_exB", exB, 32'h22);
            check("t6_hold_label", exLabel, 1);
            step();
        end
        exReady = 1'b1;
        step();
        check("t6_exec", exValid, 0);
        check("t6_exec_label", issueLabel, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", issueReady, 1);
        check("t6_rst_label", issueLabel, 1);
        check("t6_rst_exValid", exValid, 0);
        check("t6_rst_exA", exA, 0);
        step();
        rst_n = 1'b1;
        step();
        bcast(4'd1, 32'h99);
        check("t6_post_ready", issueReady, 1);
        check("t6_post_label", issueLabel, 1);
        check("t6_post_exValid", exValid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_cdb_listener.md
RS_CDB_LISTENER -- requirements
Module: rs_cdb_listener

Interface
REQ-001 Parameter DEPTH, default 3: number of reservation-station entries, range 2..4.
REQ-002 Parameter LABEL_BASE, default 4'd1: label of entry 0; entry i owns label LABEL_BASE+i; LABEL_BASE+DEPTH-1 SHALL be at most 15.
REQ-003 clk  in  1  single clock, rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 issueValid  in  1  issue request from decode.
REQ-006 issueOp  in  2  operation code carried to the functional unit.
REQ-007 issueQj / issueQk  in  4 each  producer label of operand j/k; 0 means the value is present.
REQ-008 issueVj / issueVk  in  32 each  operand value, meaningful only when the matching Q is 0.
REQ-009 issueReady  out  1  a free entry exists and issue is accepted.
REQ-010 issueLabel  out  4  label of the entry that would take the current issue.
REQ-011 cdbEN / cdbLabel / cdbData  in  1/4/32  common-data-bus broadcast, consumer side.
REQ-012 exValid  out  1  an entry is dispatching.
REQ-013 exOp / exA / exB / exLabel  out  2/32/32/4  dispatched operation, operands and destination label.
REQ-014 exReady  in  1  the functional unit accepts the dispatch.

Function
REQ-015 Each entry SHALL be in one of four states: FREE, WAIT (an operand is pending), READY (both operands present), or EXEC (dispatched, awaiting its own broadcast).
REQ-016 issueReady SHALL equal "some entry is FREE", combinational from state only.
REQ-017 issueLabel SHALL be the label of the lowest-index FREE entry.
REQ-018 When issueValid&&issueReady, at the edge the selected entry SHALL load op, Q and V, and go to READY if both effective Q are 0, else to WAIT.
REQ-019 Snoop: each cycle with cdbEN, every WAIT entry SHALL replace each operand whose Q equals a nonzero cdbLabel with cdbData and clear that Q; both operands may capture in the same cycle.
REQ-020 A WAIT entry whose last pending Q clears SHALL be READY the next cycle.
REQ-021 exValid SHALL be asserted iff some entry is READY; the lowest-index READY entry drives the ex* outputs, combinationally from registered state.
REQ-022 When exValid&&exReady, that entry SHALL go to EXEC at the edge; when exReady=0, all ex* outputs SHALL hold steady.
REQ-023 An EXEC entry SHALL go to FREE at the edge where cdbEN=1 and cdbLabel equals its own label, so a label is never reused before it is broadcast.
REQ-024 A freed entry SHALL become issuable from the following cycle, not the freeing cycle.
REQ-025 A broadcast with cdbLabel=0, or with cdbEN=0, SHALL change nothing.
REQ-026 issueValid while issueReady=0 SHALL be ignored, with no state change.
REQ-027 When nothing is valid, ex* data outputs SHALL be 0.

Reset
REQ-028 While rst_n=0, every entry SHALL be FREE with all fields 0, asynchronously.
REQ-029 Reset outputs: issueReady=1, issueLabel=LABEL_BASE, exValid=0, exOp=0, exA=0, exB=0, exLabel=0.
REQ-030 Reset during any operation SHALL discard all entries, including EXEC entries, with no further output.

Configuration
REQ-031 Macro RS_CDB_BYPASS_EN defined: at issue, an operand whose issueQ equals the same-cycle nonzero cdbLabel (cdbEN=1) SHALL load cdbData and be treated as Q=0.
REQ-032 RS_CDB_BYPASS_EN undefined: issueReady SHALL be forced to 0 in any cycle where cdbEN=1; no same-cycle bypass logic SHALL exist.

Structure
REQ-033 A shared package SHALL hold LABEL_W=4, DATA_W=32, OP_W=2, the label-0 "no producer" constant, and the entry state enumeration.
REQ-034 A sub-module rs_entry SHALL hold one entry's state machine, snoop compare and own-label free; the top holds free/ready priority selection.

Verification
REQ-035 Issue Qj=0,Vj=5,Qk=0,Vk=7, exReady=1 -> issueLabel=1; next cycle exValid=1, exA=5, exB=7, exLabel=1; CDB label 1 -> entry 1 FREE the cycle after.
REQ-036 Issue Qj=2,Qk=3 into entry 1; CDB label 2 data 0xAA, then label 3 data 0xBB -> exValid the cycle after the second broadcast, exA=0xAA, exB=0xBB.
REQ-037 Fill 3 entries with Qj=9 pending -> issueReady=0, and a 4th issueValid is ignored; CDB label 9 data 0x10 -> all three READY, dispatched in order of labels 1, 2, 3 with exReady=1.
REQ-038 Issue Qj=9 while cdbEN=1, cdbLabel=9, cdbData=0x33 -> with RS_CDB_BYPASS_EN, exA=0x33 next cycle; without it, issueReady=0 in that cycle.
REQ-039 exReady=0 for 5 cycles with a READY entry -> ex* outputs stable; assert rst_n=0 mid-EXEC -> all outputs at reset values immediately, and a later CDB of that label has no effect.
